link_sio: RTL

Game Boy serial I/O port (SB/SC registers) for the link-cable path. It shifts one byte out and one byte in per transfer, MSB first. As clock master it generates SCK from a divider; as clock slave it responds to a peer's SCK. It sits between the CPU register bus and the link-cable pins, and raises the serial interrupt request on completion.

---
 rtl/link_pkg.sv | 22 ++
 rtl/link_edge_sync.sv | 47 ++++
 rtl/link_sio.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared types and constants for the link-cable serial port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    localparam int SC_START            = 7;
    localparam int SC_INT_CLK          = 0;
    localparam int DEFAULT_HALF_PERIOD = 256;

endpackage

`default_nettype wire

// File: rtl/link_edge_sync.sv
// ============================================================================
// Module   : link_edge_sync
// Purpose  : Two-flop synchronizer for external SCK and SIN with SCK edge pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module link_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_dat,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_dat
);

    // Bit 0 carries SCK, bit 1 carries SIN so both see identical latency.
    logic [1:0] s1_q, s1_d;
    logic [1:0] s2_q, s2_d;
    logic       sck_prev_q, sck_prev_d;

    always_comb begin
        s1_d       = {i_dat, i_sck};
        s2_d       = s1_q;
        sck_prev_d = s2_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 2'b00;
            s2_q       <= 2'b00;
            sck_prev_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign o_sck_rise = s2_q[0] & ~sck_prev_q;
    assign o_sck_fall = ~s2_q[0] & sck_prev_q;
    assign o_dat      = s2_q[1];

endmodule

`default_nettype wire

// File: rtl/link_sio.sv
// ============================================================================
// Module   : link_sio
// Purpose  : Serial I/O port (SB/SC) shifting one byte MSB first over the link cable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module link_sio
    import link_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wr_sb,
    input  logic       wr_sc,
    input  logic [7:0] din,
    output logic [7:0] sb,
    output logic       sc_start,
    output logic       sc_int_clk,
    output logic       irq,
    input  logic       sck_in,
    input  logic       sin,
    output logic       sck_out,
    output logic       sck_oe,
    output logic       sout
);

    localparam logic [15:0] c_div_last = 16'(HALF_PERIOD - 1);

    state_e      state_q, state_d;
    logic [7:0]  sb_q, sb_d;
    logic        start_q, start_d;
    logic        int_clk_q, int_clk_d;
    logic        irq_q, irq_d;
    logic        sck_out_q, sck_out_d;
    logic        sout_q, sout_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] div_q, div_d;

    logic        w_ext_rise, w_ext_fall, w_sin_sync;
    logic        w_div_hit, w_rise, w_fall, w_sample;
    logic [7:0]  w_sb_new;

    link_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (sck_in),
        .i_dat      (sin),
        .o_sck_rise (w_ext_rise),
        .o_sck_fall (w_ext_fall),
        .o_dat      (w_sin_sync)
    );

    assign w_div_hit = ce && (state_q != ST_IDLE) && (div_q == c_div_last);
    assign w_rise    = (w_div_hit && state_q == ST_LOW)
                     || (!int_clk_q && start_q && w_ext_rise);
    assign w_fall    = (w_div_hit && state_q == ST_HIGH)
                     || (!int_clk_q && start_q && w_ext_fall);
    assign w_sample  = int_clk_q ? sin : w_sin_sync;
    assign w_sb_new  = wr_sb ? din : sb_q;

    always_comb begin
        state_d   = state_q;
        sb_d      = sb_q;
        start_d   = start_q;
        int_clk_d = int_clk_q;
        irq_d     = 1'b0;
        sck_out_d = sck_out_q;
        sout_d    = sout_q;
        cnt_d     = cnt_q;
        div_d     = div_q;

        if (ce && state_q != ST_IDLE) begin
            div_d = w_div_hit ? 16'd0 : div_q + 16'd1;
        end

        // A control write takes precedence over any SCK event in the same cycle.
        if (!wr_sc) begin
            if (w_rise) begin
                sb_d = {sb_q[6:0], w_sample};
                if (cnt_q == 3'd7) begin
                    cnt_d     = 3'd0;
                    start_d   = 1'b0;
                    irq_d     = 1'b1;
                    state_d   = ST_IDLE;
                    sck_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (int_clk_q) begin
                        state_d   = ST_HIGH;
                        sck_out_d = 1'b1;
                    end
                end
            end
            if (w_fall) begin
                sout_d = sb_q[7];
                if (int_clk_q) begin
                    state_d   = ST_LOW;
                    sck_out_d = 1'b0;
                end
            end
        end

        if (wr_sb) begin
            sb_d = din;
        end

        if (wr_sc) begin
            int_clk_d = din[SC_INT_CLK];
            start_d   = din[SC_START];
            cnt_d     = 3'd0;
            div_d     = 16'd0;
            state_d   = ST_IDLE;
            sck_out_d = 1'b1;
            if (din[SC_START]) begin
                sout_d = w_sb_new[7];
                if (din[SC_INT_CLK]) begin
                    state_d   = ST_LOW;
                    sck_out_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sb_q      <= 8'h00;
            start_q   <= 1'b0;
            int_clk_q <= 1'b0;
            irq_q     <= 1'b0;
            sck_out_q <= 1'b1;
            sout_q    <= 1'b1;
            cnt_q     <= 3'd0;
            div_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            sb_q      <= sb_d;
            start_q   <= start_d;
            int_clk_q <= int_clk_d;
            irq_q     <= irq_d;
            sck_out_q <= sck_out_d;
            sout_q    <= sout_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
        end
    end

    assign sb         = sb_q;
    assign sc_start   = start_q;
    assign sc_int_clk = int_clk_q;
    assign irq        = irq_q;
    assign sck_out    = sck_out_q;
    assign sck_oe     = int_clk_q;
    assign sout       = sout_q;

endmodule

`default_nettype wire
